// File: rtl/serial_alu_gen2_if.sv
// Serial ALU frame/result bundle: host drives the 3-cycle frame, ALU returns busy/done/result.
interface serial_alu_gen2_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  opcode_valid;
  logic                  opcode;
  logic [DATA_WIDTH-1:0] data;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;
  logic                  overflow;

  modport master (
    output opcode_valid, opcode, data,
    input  busy, done, result, overflow
  );

  modport slave (
    input  opcode_valid, opcode, data,
    output busy, done, result, overflow
  );
endinterface

// File: rtl/serial_alu_gen2.sv
// Serial-opcode ALU: 3-cycle frame in, 8 ops (MUL iterative shift-add), registered result + done pulse.
// Optional macro ALU_SATURATE_EN clamps ADD/SUB/MUL results on overflow.
module serial_alu_gen2 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  serial_alu_gen2_if.slave  bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_OP1  = 3'd1;
  localparam logic [2:0] S_OP2  = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_PAR = 3'b010;
  localparam logic [2:0] OP_CMP = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [2:0]     state_q, state_d;
  logic [2:0]     op_q;
  logic [W-1:0]   a_q, b_q;
  logic [2*W-1:0] mcand_q, prod_q, prod_d;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   result_q, res_d;
  logic           ovf_q, ovf_d;
  logic [W:0]     sum, diff;
  logic           mul_last;

  assign mul_last = (cnt_q == CW'(W - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.opcode_valid) state_d = S_OP1;
      S_OP1:  state_d = bus.opcode_valid ? S_OP2  : S_IDLE;
      S_OP2:  state_d = bus.opcode_valid ? S_EXEC : S_IDLE;
      S_EXEC: if (op_q != OP_MUL || mul_last) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // B is shifted right during MUL; one partial product accumulated per EXEC cycle
  always_comb begin
    sum    = {1'b0, a_q} + {1'b0, b_q};
    diff   = {1'b0, a_q} - {1'b0, b_q};
    prod_d = prod_q + (b_q[0] ? mcand_q : '0);
    res_d  = '0;
    ovf_d  = 1'b0;
    case (op_q)
      OP_ADD: begin res_d = sum[W-1:0];  ovf_d = sum[W];  end
      OP_SUB: begin res_d = diff[W-1:0]; ovf_d = diff[W]; end
      OP_PAR: res_d[0] = ^(a_q ^ b_q);
      OP_CMP: begin res_d[1] = (a_q > b_q); res_d[0] = (a_q == b_q); end
      OP_AND: res_d = a_q & b_q;
      OP_OR:  res_d = a_q | b_q;
      OP_XOR: res_d = a_q ^ b_q;
      default: begin res_d = prod_d[W-1:0]; ovf_d = |prod_d[2*W-1:W]; end
    endcase
`ifdef ALU_SATURATE_EN
    if (ovf_d && (op_q == OP_ADD || op_q == OP_MUL)) res_d = '1;
    if (ovf_d && op_q == OP_SUB)                      res_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (bus.opcode_valid) begin
          op_q[0] <= bus.opcode;
          a_q     <= bus.data;
        end
        S_OP1: if (bus.opcode_valid) begin
          op_q[1] <= bus.opcode;
          b_q     <= bus.data;
        end
        S_OP2: if (bus.opcode_valid) begin
          op_q[2] <= bus.opcode;
          mcand_q <= {{W{1'b0}}, a_q};
          prod_q  <= '0;
          cnt_q   <= '0;
        end
        S_EXEC: begin
          if (op_q == OP_MUL) begin
            prod_q  <= prod_d;
            mcand_q <= mcand_q << 1;
            b_q     <= b_q >> 1;
            cnt_q   <= cnt_q + 1'b1;
          end
          if (state_d == S_DONE) begin
            result_q <= res_d;
            ovf_q    <= ovf_d;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.result   = result_q;
  assign bus.overflow = ovf_q;
endmodule
